sb_config_loader: RTL and testbench



---
 rtl/clb_cfg_pkg.sv | 19 +
 rtl/sb_cfg_shadow.sv | 47 ++++
 rtl/sb_config_loader.sv | 108 ++++++++++
 tb/tb_sb_config_loader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/clb_cfg_pkg.sv
// Shared types and width helpers for the CLB switch-box configuration path.
// Used by the loader, its shadow store and the switch-box wrapper.
package clb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } cfg_state_e;

  function automatic int sb_cfg_width(input int ws, input int wd);
    return (ws + wd / 2) * 6;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/sb_cfg_shadow.sv
// Shadow image store: decodes word_cnt into box/slot enables, masks last slot.
// Ports: clk, rst_n, we_i, cnt_i, data_i -> shadow_o (NUM_SB*CW bits).
module sb_cfg_shadow
  import clb_cfg_pkg::*;
#(
  parameter int WS     = 8,
  parameter int WD     = 8,
  parameter int NUM_SB = 4,
  parameter int DATA_W = 8,
  localparam int CW    = sb_cfg_width(WS, WD),
  localparam int WPB   = ceil_div(CW, DATA_W),
  localparam int TOTAL = NUM_SB * WPB,
  localparam int CNT_W = $clog2(TOTAL + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_i,
  input  logic [CNT_W-1:0]       cnt_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic [NUM_SB*CW-1:0]   shadow_o
);

  localparam int LAST_W = CW - (WPB - 1) * DATA_W;

  logic [NUM_SB*CW-1:0] shadow_q;
  logic [NUM_SB*CW-1:0] shadow_d;

  for (genvar b = 0; b < NUM_SB; b++) begin : g_box
    for (genvar s = 0; s < WPB; s++) begin : g_slot
      localparam int LO = b * CW + s * DATA_W;
      // last slot of a box only holds the leftover config bits
      localparam int SW = (s == WPB - 1) ? LAST_W : DATA_W;
      logic hit;
      assign hit = we_i && (cnt_i == CNT_W'(b * WPB + s));
      assign shadow_d[LO +: SW] =
        hit ? data_i[SW-1:0] : shadow_q[LO +: SW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/sb_config_loader.sv
// Word-serial bitstream loader; commits the shadow image atomically to cfg_out.
// Ports: start/abort, in_valid/in_data/in_ready, busy, done, cfg_valid, cfg_out.
module sb_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int WS     = 8,
  parameter int WD     = 8,
  parameter int NUM_SB = 4,
  parameter int DATA_W = 8,
  localparam int CW    = sb_cfg_width(WS, WD),
  localparam int WPB   = ceil_div(CW, DATA_W),
  localparam int TOTAL = NUM_SB * WPB,
  localparam int CNT_W = $clog2(TOTAL + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_valid,
  output logic [NUM_SB*CW-1:0] cfg_out
);

  cfg_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic busy_q, done_q, cv_q;
  logic [NUM_SB*CW-1:0] cfg_q, shadow;
  logic hs, commit;

  assign in_ready = (state_q == LOAD) && !abort;
  assign hs       = in_valid && in_ready;

  sb_cfg_shadow #(
    .WS    (WS),
    .WD    (WD),
    .NUM_SB(NUM_SB),
    .DATA_W(DATA_W)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (hs),
    .cnt_i   (cnt_q),
    .data_i  (in_data),
    .shadow_o(shadow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (hs) begin
          if (cnt_q == CNT_W'(TOTAL - 1)) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        commit  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cv_q    <= 1'b0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= commit;
      if (commit) begin
        cv_q  <= 1'b1;
        cfg_q <= shadow;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_valid = cv_q;
  assign cfg_out   = cfg_q;

endmodule

// File: tb/tb_sb_config_loader.sv
// Randomized self-checking bench for sb_config_loader (WD=8 and WD=6 builds).
// A word-level image model predicts handshakes, done, cfg_valid and cfg_out.
module tb_sb_config_loader;

  localparam int NB  = 4;
  localparam int DW  = 8;
  localparam int CWA = 72;
  localparam int CWB = 66;
  localparam int WPB = 9;
  localparam int TOT = NB * WPB;

  logic clk = 1'b0;
  logic rst_n, start, abort, in_valid;
  logic [DW-1:0] in_data;

  logic rdy_a, busy_a, done_a, cv_a;
  logic rdy_b, busy_b, done_b, cv_b;
  logic [NB*CWA-1:0] cfg_a;
  logic [NB*CWB-1:0] cfg_b;

  always #5 clk = ~clk;

  sb_config_loader #(.WS(8), .WD(8), .NUM_SB(NB), .DATA_W(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
    .busy(busy_a), .done(done_a), .cfg_valid(cv_a), .cfg_out(cfg_a)
  );

  sb_config_loader #(.WS(8), .WD(6), .NUM_SB(NB), .DATA_W(DW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
    .busy(busy_b), .done(done_b), .cfg_valid(cv_b), .cfg_out(cfg_b)
  );

  // reference model
  bit m_load, m_commit, m_done, m_cv;
  int m_cnt;
  int n_acc;
  logic [NB*CWA-1:0] sh_a, cf_a;
  logic [NB*CWB-1:0] sh_b, cf_b;
  logic [DW-1:0] words [TOT];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [287:0] got,
                     input logic [287:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_load = 0; m_commit = 0; m_done = 0; m_cv = 0; m_cnt = 0;
    sh_a = '0; cf_a = '0; sh_b = '0; cf_b = '0;
  endtask

  // store word d as image word index m_cnt in both shadow models
  task automatic put_word(input logic [DW-1:0] d);
    int box, pos;
    box = m_cnt / WPB;
    for (int j = 0; j < DW; j++) begin
      pos = (m_cnt % WPB) * DW + j;
      if (pos < CWA) sh_a[box*CWA+pos] = d[j];
      if (pos < CWB) sh_b[box*CWB+pos] = d[j];
    end
    words[m_cnt] = d;
  endtask

  task automatic cyc(input bit st, input bit ab, input bit v,
                     input logic [DW-1:0] d);
    bit er, acc;
    @(negedge clk);
    start = st; abort = ab; in_valid = v; in_data = d;
    #1;
    er = m_load && !ab;
    chk("in_ready_a", rdy_a, er);
    chk("in_ready_b", rdy_b, er);
    acc = v && er;
    @(posedge clk);
    m_done = 0;
    if (m_commit) begin
      cf_a = sh_a; cf_b = sh_b;
      m_cv = 1; m_commit = 0; m_done = 1;
    end else if (m_load) begin
      if (ab) begin
        m_load = 0; m_cnt = 0;
      end else if (acc) begin
        put_word(d);
        n_acc++;
        if (m_cnt == TOT - 1) begin
          m_load = 0; m_commit = 1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end else if (st) begin
      m_load = 1; m_cnt = 0;
    end
    #1;
    chk("busy_a", busy_a, m_load || m_commit);
    chk("busy_b", busy_b, m_load || m_commit);
    chk("done_a", done_a, m_done);
    chk("done_b", done_b, m_done);
    chk("cfg_valid_a", cv_a, m_cv);
    chk("cfg_valid_b", cv_b, m_cv);
    chk("cfg_out_a", cfg_a, cf_a);
    chk("cfg_out_b", cfg_b, cf_b);
  endtask

  // mode 0: 8'h10+i; 1: random with 8'hFF last slot; 2: valid toggles;
  // 3: random valid with stray start pulses
  task automatic run_load(input int mode);
    int base, i;
    bit v, st;
    logic [DW-1:0] d;
    base = n_acc;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 400 && m_load; k++) begin
      i  = n_acc - base;
      v  = (mode == 2) ? (k % 2 == 0) :
           (mode == 3) ? ($urandom % 3 != 0) : 1'b1;
      st = (mode == 3) && ($urandom % 4 == 0);
      if (mode == 0) d = 8'(8'h10 + i);
      else if (mode == 1 && (i % WPB) == WPB - 1) d = 8'hFF;
      else d = 8'($urandom);
      cyc(st, 1'b0, v, d);
    end
    chk("accepts", 32'(n_acc - base), 32'(TOT));
    cyc(mode == 3, 1'b0, 1'b0, '0);
  endtask

  logic [NB*CWA-1:0] img_a;

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; in_data = '0;
    n_acc = 0;
    model_reset();
    #3;
    chk("rst_in_ready", rdy_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_cfg_valid", cv_a, 1'b0);
    chk("rst_cfg_out", cfg_a, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_load(0);
    chk("box0_w0", cfg_a[7:0], 8'h10);
    chk("box0_w8", cfg_a[71:64], 8'h18);
    chk("box1_w0", cfg_a[79:72], 8'h19);
    // start in the done cycle is honoured
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("b2b_busy", busy_a, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0);

    run_load(1);
    chk("mask_b_slot", cfg_b[65:64], 2'b11);
    chk("mask_b_box1", cfg_b[66], words[9][0]);
    chk("mask_a_slot", cfg_a[71:64], 8'hFF);

    run_load(2);
    run_load(3);

    // abort after 10 words, with in_valid high in the abort cycle
    img_a = cf_a;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom));
    cyc(1'b0, 1'b1, 1'b1, 8'($urandom));
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 8'($urandom));
    chk("abort_keep", cfg_a, img_a);
    run_load(1);

    // random control traffic
    for (int k = 0; k < 1500; k++)
      cyc($urandom % 8 == 0, $urandom % 40 == 0, $urandom % 4 != 0,
          8'($urandom));
    run_load(0);

    // asynchronous reset in the middle of a load
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cfg_out", cfg_a, '0);
    chk("arst_cfg_valid", cv_a, 1'b0);
    chk("arst_busy", busy_a, 1'b0);
    chk("arst_in_ready", rdy_a, 1'b0);
    chk("arst_cfg_out_b", cfg_b, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_load(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
